// File: rtl/counter_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_sequencer: prescaled one-shot/auto-reload counter, IDLE/RUN/PAUSE/DONE. Rev 1.0 |
// +--------------------------------------------------------------------------+
module counter_sequencer #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pause,
  input  logic       i_mode,
  input  logic [3:0] i_term,
  output logic [3:0] o_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_wrap
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUN     = 2'd1;
  localparam logic [1:0] c_PAUSE   = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;
  localparam logic [3:0] c_PRE_MAX = 4'(DIV - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_presc;
  logic [3:0] r_term_q;
  logic       r_mode_q;
  logic [3:0] w_count_nxt;
  logic [3:0] w_presc_nxt;
  logic [3:0] w_term_nxt;
  logic       w_mode_nxt;
  logic       w_done_nxt;
  logic       w_wrap_nxt;
  logic       w_busy_nxt;
  logic       w_run_edge;
  logic       w_tick;
  logic       w_at_term;
  logic       w_launch;

  assign w_run_edge = (r_state == c_RUN) && !i_pause && !i_stop;
  assign w_tick     = w_run_edge && (r_presc == c_PRE_MAX);
  assign w_at_term  = (o_count == r_term_q);
  assign w_launch   = ((r_state == c_IDLE) || (r_state == c_DONE)) && i_start && !i_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_launch) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (i_stop)                              w_state_nxt = c_IDLE;
        else if (i_pause)                        w_state_nxt = c_PAUSE;
        else if (w_tick && w_at_term && !r_mode_q) w_state_nxt = c_DONE;
      end
      c_PAUSE: begin
        if (i_stop)        w_state_nxt = c_IDLE;
        else if (!i_pause) w_state_nxt = c_RUN;
      end
      c_DONE: begin
        if (i_stop)        w_state_nxt = c_IDLE;
        else if (w_launch) w_state_nxt = c_RUN;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Stop outranks start, pause and tick; only an unpaused RUN edge moves the datapath.
  always_comb begin
    w_count_nxt = o_count;
    w_presc_nxt = r_presc;
    w_term_nxt  = r_term_q;
    w_mode_nxt  = r_mode_q;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_busy_nxt  = (w_state_nxt == c_RUN) || (w_state_nxt == c_PAUSE);
    if (i_stop) begin
      w_count_nxt = 4'd0;
      w_presc_nxt = 4'd0;
    end else if (w_launch) begin
      w_count_nxt = 4'd0;
      w_presc_nxt = 4'd0;
      w_term_nxt  = i_term;
      w_mode_nxt  = i_mode;
    end else if (w_run_edge) begin
      w_presc_nxt = w_tick ? 4'd0 : r_presc + 4'd1;
      if (w_tick) begin
        if (!w_at_term) begin
          w_count_nxt = o_count + 4'd1;
        end else if (r_mode_q) begin
          w_count_nxt = 4'd0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count  <= 4'd0;
      r_presc  <= 4'd0;
      r_term_q <= 4'd0;
      r_mode_q <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_wrap   <= 1'b0;
    end else begin
      o_count  <= w_count_nxt;
      r_presc  <= w_presc_nxt;
      r_term_q <= w_term_nxt;
      r_mode_q <= w_mode_nxt;
      o_busy   <= w_busy_nxt;
      o_done   <= w_done_nxt;
      o_wrap   <= w_wrap_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: DIV, default 1, count advances once every DIV enabled clocks; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: reset=0 forces reset state immediately, independent of clk.
REQ-004 start  input  1  begin a count run; level sampled each edge.
REQ-005 stop  input  1  abort run, return to IDLE.
REQ-006 pause  input  1  hold count and prescaler while high.
REQ-007 mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
REQ-008 term  input  4  terminal count value; latched at start.
REQ-009 count  output  4  current count value, registered.
REQ-010 busy  output  1  high in RUN and PAUSE.
REQ-011 done  output  1  one-cycle pulse on one-shot completion, registered.
REQ-012 wrap  output  1  one-cycle pulse on auto-reload wrap, registered.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-014 The block SHALL keep a prescaler 0..DIV-1; tick = state RUN and pause=0 and stop=0 and prescaler==DIV-1.
REQ-015 On a RUN edge with pause=0 and stop=0, the prescaler SHALL wrap to 0 on tick, else increment.
REQ-016 IDLE or DONE, start=1, stop=0: next state RUN, count 0, prescaler 0, term_q<=term, mode_q<=mode.
REQ-017 With DIV=1, a start sampled at edge k SHALL yield count=1 after edge k+1.
REQ-018 On tick with count!=term_q, count SHALL increment by 1.
REQ-019 On tick with count==term_q and mode_q=0, next state SHALL be DONE, count holds term_q, done=1 for exactly the first DONE cycle.
REQ-020 On tick with count==term_q and mode_q=1, count SHALL go to 0, state stays RUN, wrap=1 for exactly the following cycle.
REQ-021 term_q=0: one-shot SHALL reach DONE on the first tick; auto-reload SHALL pulse wrap every tick with count held 0.
REQ-022 Count SHALL never exceed term_q; no 4-bit overflow path exists.
REQ-023 RUN with pause=1 (stop=0): next state PAUSE; count and prescaler frozen; no tick that edge.
REQ-024 PAUSE with pause=0 (stop=0): next state RUN; prescaler resumes from held value.
REQ-025 stop=1 in RUN, PAUSE or DONE: next state IDLE, count 0, prescaler 0, no done/wrap pulse; stop has priority over start, pause and tick.
REQ-026 start SHALL be ignored in RUN and PAUSE; term/mode changes SHALL not affect an active run.
REQ-027 DONE SHALL hold count=term_q until start (restart) or stop (to IDLE).
REQ-028 busy SHALL be registered and equal (state==RUN or state==PAUSE).

Reset
REQ-029 While reset=0: state IDLE, count 0, prescaler 0, term_q 0, mode_q 0, busy 0, done 0, wrap 0.
REQ-030 Reset assertion mid-run SHALL abort immediately with no done/wrap pulse; after release, state IDLE until a start.

Verification
REQ-031 DIV=1, term=3, mode=0, start 1 cycle -> count 0,1,2,3 on successive edges; done=1 one cycle after count reaches 3 tick; busy falls with DONE; count holds 3.
REQ-032 DIV=1, term=2, mode=1, run 9 cycles -> count 0,1,2,0,1,2,0,...; wrap pulses 1 cycle after each 2->0; done never asserts.
REQ-033 DIV=4, term=1, mode=0 -> count reaches 1 after 4 RUN cycles, DONE after 8; pause=1 for 5 cycles mid-run extends timeline by exactly 5 cycles, prescaler value preserved.
REQ-034 stop asserted same cycle as terminal tick (term=2, mode=0) -> IDLE, count 0, done stays 0; start during RUN with term=7 -> ignored, run still ends at 2.
REQ-035 reset=0 asynchronously between clock edges at count=5 -> count 0, busy 0 immediately; release then start with term=0, mode=1 -> wrap pulses every cycle, count 0.
